fnd_scan_controller: RTL
========================

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter VALUE_W, default 14, meaning the binary input width (legal range 4..27).
REQ-003 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each digit stays enabled (legal range ≥2).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_value, input, VALUE_W bits: unsigned binary value to display.
REQ-007 SHALL have port i_load, input, 1 bit: single-cycle request to capture i_value.
REQ-008 SHALL have port i_dp, input, DIGITS bits: per-digit decimal-point enable, sampled live.
REQ-009 SHALL have port i_en, input, 1 bit: display enable.
REQ-010 SHALL have port o_digit, output, DIGITS bits: active-low one-hot digit enable, bit 0 = least significant digit.
REQ-011 SHALL have port o_fndFont, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-012 SHALL have port o_busy, output, 1 bit: conversion in progress.
REQ-013 SHALL have port o_ovf, output, 1 bit: the displayed value exceeds 10^DIGITS-1.

Function
REQ-014 SHALL use a scan counter 0..SCAN_DIV-1; at terminal count the digit index SHALL advance and wrap from DIGITS-1 to 0.
REQ-015 SHALL drive o_digit and o_fndFont from registers with 1-cycle latency from the digit index, i_dp and i_en.
REQ-016 SHALL use font codes 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, dp bit set); i_dp[k]=1 SHALL clear bit 7 while digit k is active.
REQ-017 When i_en=0, SHALL drive o_digit all ones and o_fndFont=FF; the scan counter and index SHALL keep running.
REQ-018 SHALL implement FSM IDLE -> SHIFT -> COMMIT -> IDLE performing a sequential double-dabble conversion.
REQ-019 In IDLE, i_load=1 SHALL capture i_value, move to SHIFT and set o_busy on the next cycle.
REQ-020 SHIFT SHALL last exactly VALUE_W cycles, processing one bit per cycle: add-3 to every BCD nibble ≥5, then shift left.
REQ-021 COMMIT SHALL update all displayed digits and o_ovf atomically in one cycle, then return to IDLE with o_busy=0.
REQ-022 The new value SHALL appear on the outputs by VALUE_W+3 cycles after i_load; the display SHALL hold the previous value until COMMIT.
REQ-023 i_load SHALL be ignored while o_busy=1, with no queuing.
REQ-024 If the captured value exceeds 10^DIGITS-1, o_ovf SHALL be 1 and every digit SHALL show "-" (BF, dp still per i_dp); otherwise o_ovf SHALL be 0.

Reset
REQ-025 i_reset SHALL set: FSM=IDLE, o_busy=0, o_ovf=0, all displayed digits=0, scan counter=0, index=0, o_digit all ones, o_fndFont=FF.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no COMMIT.
REQ-027 In the first cycle after reset with i_en=1, the outputs SHALL show digit 0 active with font C0.

Configuration
REQ-028 With macro LEADING_ZERO_BLANK_EN defined, zero digits above the most significant non-zero digit SHALL show FF (dp still honoured), digit 0 SHALL never be blanked, and overflow display SHALL be unaffected.
REQ-029 Without LEADING_ZERO_BLANK_EN, all digits SHALL show their BCD value including leading zeros.

Verification (DIGITS=4, VALUE_W=14, SCAN_DIV=4)
REQ-030 Reset, then i_en=1 -> o_digit=1110 and o_fndFont=C0; index advances every 4 cycles in the order 1110, 1101, 1011, 0111, 1110.
REQ-031 i_load with i_value=1234 -> o_busy high for 15 cycles; then digits 0..3 show 99, B0, A4, F9; o_ovf=0.
REQ-032 i_value=12345 loaded -> o_ovf=1 and all digits show BF; a later load of 9999 -> 90 on all digits, o_ovf=0.
REQ-033 i_value=7 with LEADING_ZERO_BLANK_EN -> digit0=F8, digits 1..3=FF; without the macro -> digits 1..3=C0; i_dp=0010 -> digit1 bit 7 cleared.
REQ-034 Second i_load while busy -> ignored, first value displayed; i_reset pulsed mid-SHIFT -> display 0, o_busy=0.
REQ-035 i_en=0 for 10 cycles -> o_digit=1111 and o_fndFont=FF; on re-enable the index resumes at its free-running position.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: multiplexed 7-segment (FND) driver with a sequential
// double-dabble binary-to-BCD converter.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank zero digits above
// the most significant non-zero digit (digit 0 is never blanked).
module fnd_scan_controller #(
  parameter int DIGITS   = 4,
  parameter int VALUE_W  = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  input  logic [DIGITS-1:0]  i_dp,
  input  logic               i_en,
  output logic [DIGITS-1:0]  o_digit,
  output logic [7:0]         o_fndFont,
  output logic               o_busy,
  output logic               o_ovf
);

  // BCD work register holds every decimal digit of the widest input value,
  // and at least DIGITS nibbles so the displayed slice always exists.
  localparam int NB = (DIGITS > (VALUE_W + 3) / 3) ? DIGITS : (VALUE_W + 3) / 3;
  localparam int BW = NB * 4;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int KW = $clog2(VALUE_W);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [VALUE_W-1:0]  shreg;
  logic [BW-1:0]       bcd;
  logic [KW-1:0]       bit_cnt;
  logic [DIGITS*4-1:0] disp;
  logic                ovf;
  logic                ovf_c;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   digit_c;
  logic [7:0]          font_c;
`ifdef LEADING_ZERO_BLANK_EN
  logic                nz_seen;
`endif

  // One double-dabble step: add 3 to every nibble >= 5, then shift in bin.
  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] b, input logic bin);
    logic [BW-1:0] r;
    r = b;
    for (int k = 0; k < NB; k++) begin
      if (r[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
    end
    r = (r << 1) | BW'(bin);
    return r;
  endfunction

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} with dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign o_busy = (state != IDLE);
  assign o_ovf  = ovf;

  // Free-running scan timer and digit index; keeps running while disabled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state: SHIFT runs one cycle per input bit, COMMIT is a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_load) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == KW'(VALUE_W - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath: capture on load, one bit per SHIFT cycle.
  always_ff @(posedge i_clk) begin
    case (state)
      IDLE: begin
        if (i_load) begin
          shreg   <= i_value;
          bcd     <= '0;
          bit_cnt <= '0;
        end
      end
      SHIFT: begin
        bcd     <= dabble_step(bcd, shreg[VALUE_W-1]);
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  // Any non-zero nibble above the displayed digits means the value won't fit.
  always_comb begin
    ovf_c = 1'b0;
    for (int k = DIGITS; k < NB; k++) begin
      ovf_c = ovf_c | (bcd[k*4 +: 4] != 4'd0);
    end
  end

  // Displayed digits and overflow flag change together, only in COMMIT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      disp <= '0;
      ovf  <= 1'b0;
    end else if (state == COMMIT) begin
      disp <= bcd[DIGITS*4-1:0];
      ovf  <= ovf_c;
    end
  end

  // Leading-zero blanking mask (all zeros unless the feature is enabled).
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    nz_seen = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      nz_seen  = nz_seen | (disp[k*4 +: 4] != 4'd0);
      blank[k] = !nz_seen;
    end
`endif
  end

  // Select the active digit and build its font; dp follows i_dp live.
  always_comb begin
    cur_nib   = disp[3:0];
    cur_dp    = i_dp[0];
    cur_blank = blank[0];
    digit_c   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib    = disp[k*4 +: 4];
        cur_dp     = i_dp[k];
        cur_blank  = blank[k];
        digit_c[k] = 1'b0;
      end
    end
    if (ovf)            font_c = 8'hBF;
    else if (cur_blank) font_c = 8'hFF;
    else                font_c = seg7(cur_nib);
    if (cur_dp) font_c[7] = 1'b0;
  end

  // Registered outputs, forced dark on reset or when the display is disabled.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      o_digit   <= '1;
      o_fndFont <= 8'hFF;
    end else begin
      o_digit   <= digit_c;
      o_fndFont <= font_c;
    end
  end

endmodule
